// File: rtl/algo_1r1w_rdbuf.sv
// algo_1r1w_rdbuf: credit-based read adapter that buffers the fixed-latency returns of the 1r1w memory.
// Define RDBUF_BYPASS_EN to hand a return straight to a ready consumer when the response FIFO is empty.
module algo_1r1w_rdbuf #(
    parameter int WIDTH    = 32,
    parameter int BITADDR  = 13,
    parameter int DEPTH    = 4,
    parameter int BITDEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_ready,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic [BITADDR-1:0]  req_adr,
    output logic                mem_read,
    output logic [BITADDR-1:0]  mem_rd_adr,
    input  logic                mem_rd_vld,
    input  logic [WIDTH-1:0]    mem_rd_dout,
    output logic                rsp_vld,
    input  logic                rsp_rdy,
    output logic [WIDTH-1:0]    rsp_data,
    output logic [BITDEPTH:0]   fifo_cnt,
    output logic [BITDEPTH:0]   infl_cnt,
    output logic                err
);

    localparam int CW = BITDEPTH + 1;
    localparam logic [BITDEPTH+1:0]  CREDIT_LIMIT = (BITDEPTH+2)'(DEPTH);
    localparam logic [CW-1:0]        CNT_ONE      = CW'(1);
    localparam logic [BITDEPTH-1:0]  PTR_ONE      = BITDEPTH'(1);

    logic [CW-1:0]        fifo_cnt_reg, fifo_cnt_next;
    logic [CW-1:0]        infl_cnt_reg, infl_cnt_next;
    logic [BITDEPTH-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [BITDEPTH-1:0]  rd_ptr_reg, rd_ptr_next;
    logic                 err_reg, err_next;

    logic [BITDEPTH+1:0]  credit_sum;
    logic                 credit_ok;
    logic                 issue;
    logic                 ret_ok;
    logic                 ret_spurious;
    logic                 bypass;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [WIDTH-1:0]     entry_data [DEPTH];

    // Credit counts every slot already promised: reads in flight plus data waiting in the FIFO.
    assign credit_sum = {1'b0, infl_cnt_reg} + {1'b0, fifo_cnt_reg};
    assign credit_ok  = credit_sum < CREDIT_LIMIT;
    assign req_rdy    = !rst && mem_ready && credit_ok;
    assign issue      = req_vld && req_rdy;
    assign mem_read   = issue;
    assign mem_rd_adr = req_adr;

    assign fifo_empty   = (fifo_cnt_reg == '0);
    assign ret_ok       = mem_rd_vld && (infl_cnt_reg != '0);
    assign ret_spurious = mem_rd_vld && (infl_cnt_reg == '0);

`ifdef RDBUF_BYPASS_EN
    assign bypass = ret_ok && fifo_empty && rsp_rdy;
`else
    assign bypass = 1'b0;
`endif

    assign push     = ret_ok && !bypass;
    assign pop      = !fifo_empty && rsp_rdy;
    assign rsp_vld  = !fifo_empty || bypass;
    assign rsp_data = bypass ? mem_rd_dout : entry_data[rd_ptr_reg];

    assign fifo_cnt = fifo_cnt_reg;
    assign infl_cnt = infl_cnt_reg;
    assign err      = err_reg;

    // Per-entry storage; a slot is only written when credit has reserved it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] data_reg;

        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == BITDEPTH'(gi))) begin
                data_reg <= mem_rd_dout;
            end
        end

        assign entry_data[gi] = data_reg;
    end

    always_comb begin
        infl_cnt_next = infl_cnt_reg;
        fifo_cnt_next = fifo_cnt_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        err_next      = err_reg | ret_spurious;

        case ({issue, ret_ok})
            2'b10:   infl_cnt_next = infl_cnt_reg + CNT_ONE;
            2'b01:   infl_cnt_next = infl_cnt_reg - CNT_ONE;
            default: infl_cnt_next = infl_cnt_reg;
        endcase

        case ({push, pop})
            2'b10:   fifo_cnt_next = fifo_cnt_reg + CNT_ONE;
            2'b01:   fifo_cnt_next = fifo_cnt_reg - CNT_ONE;
            default: fifo_cnt_next = fifo_cnt_reg;
        endcase

        // Pointers are BITDEPTH wide, so the increment wraps modulo DEPTH.
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            infl_cnt_reg <= '0;
            fifo_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            infl_cnt_reg <= infl_cnt_next;
            fifo_cnt_reg <= fifo_cnt_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            err_reg      <= err_next;
        end
    end

endmodule

// File: tb/tb_algo_1r1w_rdbuf.sv
// Bench for algo_1r1w_rdbuf: a latency-2 memory model, a queue-level reference model and directed scenarios.
module tb_algo_1r1w_rdbuf;
    localparam int WIDTH    = 32;
    localparam int BITADDR  = 13;
    localparam int DEPTH    = 4;
    localparam int BITDEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                mem_ready;
    logic                req_vld;
    logic                req_rdy;
    logic [BITADDR-1:0]  req_adr;
    logic                mem_read;
    logic [BITADDR-1:0]  mem_rd_adr;
    logic                mem_rd_vld;
    logic [WIDTH-1:0]    mem_rd_dout;
    logic                rsp_vld;
    logic                rsp_rdy;
    logic [WIDTH-1:0]    rsp_data;
    logic [BITDEPTH:0]   fifo_cnt;
    logic [BITDEPTH:0]   infl_cnt;
    logic                err;

    algo_1r1w_rdbuf #(
        .WIDTH(WIDTH), .BITADDR(BITADDR), .DEPTH(DEPTH), .BITDEPTH(BITDEPTH)
    ) dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_adr(req_adr),
        .mem_read(mem_read), .mem_rd_adr(mem_rd_adr),
        .mem_rd_vld(mem_rd_vld), .mem_rd_dout(mem_rd_dout),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .fifo_cnt(fifo_cnt), .infl_cnt(infl_cnt), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // Memory model: two-stage return pipeline, cleared when the memory is reset.
    logic                pv0 = 1'b0, pv1 = 1'b0, ov0 = 1'b0, ov1 = 1'b0;
    logic [BITADDR-1:0]  pa0 = '0, pa1 = '0;
    logic                spur = 1'b0;
    logic [WIDTH-1:0]    spur_data = '0;
    logic                ovr_next = 1'b0;

    // Reference model: FIFO contents, reads in flight, sticky error, expected response order.
    logic [WIDTH-1:0]    mq[$];
    logic [WIDTH-1:0]    sbq[$];
    int                  m_infl = 0;
    bit                  m_err = 1'b0;
    int                  rsp_count = 0;
    bit                  last_issue;

    bit                  obs_mem_read, obs_req_rdy, obs_rsp_vld, obs_err;
    logic [WIDTH-1:0]    obs_rsp_data;
    logic [BITDEPTH:0]   obs_fifo_cnt, obs_infl_cnt;

    function automatic logic [WIDTH-1:0] memdata(input logic [BITADDR-1:0] a);
        return {16'hA5C3, 3'b000, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        bit                 e_rdy, e_read, e_bypass, e_rsp_vld, acc_ret, pop, rst_s, ret_vld;
        logic [WIDTH-1:0]   e_data, ret_data, issue_data;
        int                 occ;
        mem_rd_vld  = pv1 | spur;
        mem_rd_dout = spur ? spur_data : (ov1 ? 32'h1234_5678 : memdata(pa1));
        #1;
        occ     = m_infl + mq.size();
        e_rdy   = !rst && mem_ready && (occ < DEPTH);
        e_read  = req_vld && e_rdy;
        acc_ret = mem_rd_vld && (m_infl > 0);
`ifdef RDBUF_BYPASS_EN
        e_bypass = acc_ret && (mq.size() == 0) && rsp_rdy;
`else
        e_bypass = 1'b0;
`endif
        e_rsp_vld = (mq.size() != 0) || e_bypass;
        e_data    = e_bypass ? mem_rd_dout : ((mq.size() != 0) ? mq[0] : '0);

        chk("req_rdy", req_rdy, e_rdy);
        chk("mem_read", mem_read, e_read);
        if (e_read) chk("mem_rd_adr", mem_rd_adr, req_adr);
        chk("rsp_vld", rsp_vld, e_rsp_vld);
        if (e_rsp_vld) chk("rsp_data", rsp_data, e_data);
        chk("fifo_cnt", fifo_cnt, occ - m_infl);
        chk("infl_cnt", infl_cnt, m_infl);
        chk("err", err, m_err);

        obs_mem_read = mem_read;  obs_req_rdy  = req_rdy;  obs_rsp_vld = rsp_vld;
        obs_rsp_data = rsp_data;  obs_fifo_cnt = fifo_cnt; obs_infl_cnt = infl_cnt;
        obs_err      = err;

        pop = e_rsp_vld && rsp_rdy;
        if (pop) begin
            rsp_count++;
            if (sbq.size() > 0) begin
                chk("order", rsp_data, sbq.pop_front());
            end else begin
                checks++;
                errors++;
                $display("FAIL order: response 0x%0h with no outstanding request", rsp_data);
            end
        end
        last_issue = e_read;
        rst_s      = rst;
        ret_vld    = mem_rd_vld;
        ret_data   = mem_rd_dout;
        issue_data = ovr_next ? 32'h1234_5678 : memdata(req_adr);

        @(posedge clk);
        if (rst_s) begin
            mq.delete();
            sbq.delete();
            m_infl = 0;
            m_err  = 1'b0;
        end else begin
            if (pop && !e_bypass) void'(mq.pop_front());
            if (ret_vld) begin
                if (acc_ret) begin
                    if (!e_bypass) mq.push_back(ret_data);
                    m_infl--;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (e_read) begin
                m_infl++;
                sbq.push_back(issue_data);
            end
        end

        @(negedge clk);
        if (rst_s) begin
            pv0 = 1'b0; pv1 = 1'b0; ov0 = 1'b0; ov1 = 1'b0;
        end else begin
            pv1 = pv0; pa1 = pa0; ov1 = ov0;
            pv0 = e_read; pa0 = req_adr; ov0 = e_read && ovr_next;
        end
        spur = 1'b0;
    endtask

    task automatic issue_seq(input int base, input int n, output int cyc);
        int done = 0;
        cyc = 0;
        req_vld = 1'b1;
        while (done < n && cyc < 200) begin
            req_adr = BITADDR'(base + done);
            cycle();
            cyc++;
            if (last_issue) done++;
        end
        req_vld = 1'b0;
    endtask

    task automatic drain(input int target);
        req_vld = 1'b0;
        for (int i = 0; i < 60 && rsp_count < target; i++) cycle();
    endtask

    int cyc, n_acc, idx;

    initial begin
        rst = 1'b1; mem_ready = 1'b1; req_vld = 1'b1; req_adr = 13'h10; rsp_rdy = 1'b1;
        mem_rd_vld = 1'b0; mem_rd_dout = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset with a pending request
        cycle();
        cycle();
        chk("rst_req_rdy", obs_req_rdy, 0);
        chk("rst_mem_read", obs_mem_read, 0);
        chk("rst_rsp_vld", obs_rsp_vld, 0);
        chk("rst_fifo_cnt", obs_fifo_cnt, 0);
        chk("rst_infl_cnt", obs_infl_cnt, 0);
        chk("rst_err", obs_err, 0);
        rst = 1'b0; req_vld = 1'b0;
        cycle();

        // Streaming 0x10..0x17 with a ready consumer
        rsp_count = 0;
        issue_seq(32'h10, 8, cyc);
        chk("stream_issue_cycles", cyc, 8);
        drain(8);
        chk("stream_rsp_count", rsp_count, 8);

        // Backpressure: consumer stalled while 0x0..0x7 are requested
        rsp_rdy = 1'b0; rsp_count = 0; idx = 0; n_acc = 0;
        req_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_adr = BITADDR'(idx);
            cycle();
            if (obs_mem_read) n_acc++;
            if (last_issue) idx++;
        end
        chk("bp_accepted", n_acc, 4);
        chk("bp_fifo_full", obs_fifo_cnt, 4);
        chk("bp_req_rdy", obs_req_rdy, 0);
        rsp_rdy = 1'b1;
        issue_seq(idx, 8 - idx, cyc);
        drain(8);
        chk("bp_rsp_count", rsp_count, 8);

        // mem_ready held low
        mem_ready = 1'b0; req_vld = 1'b1; req_adr = 13'h100; n_acc = 0; rsp_count = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (obs_mem_read) n_acc++;
        end
        chk("mrdy_low_issues", n_acc, 0);
        mem_ready = 1'b1;
        cycle();
        chk("mrdy_first_issue", obs_mem_read, 1);
        drain(1);
        chk("mrdy_rsp_count", rsp_count, 1);

        // Single read into an empty FIFO returning 0x12345678
        rsp_count = 0;
        ovr_next = 1'b1; req_vld = 1'b1; req_adr = 13'h55;
        cycle();
        chk("byp_issue", obs_mem_read, 1);
        ovr_next = 1'b0; req_vld = 1'b0;
        cycle();
        cycle();
`ifdef RDBUF_BYPASS_EN
        chk("byp_same_cycle_vld", obs_rsp_vld, 1);
        chk("byp_same_cycle_data", obs_rsp_data, 32'h1234_5678);
        cycle();
        chk("byp_fifo_cnt", obs_fifo_cnt, 0);
        chk("byp_after_vld", obs_rsp_vld, 0);
`else
        chk("nobyp_same_cycle_vld", obs_rsp_vld, 0);
        cycle();
        chk("nobyp_next_vld", obs_rsp_vld, 1);
        chk("nobyp_next_data", obs_rsp_data, 32'h1234_5678);
        chk("nobyp_fifo_cnt", obs_fifo_cnt, 1);
`endif
        drain(1);
        chk("byp_rsp_count", rsp_count, 1);

        // Reset with reads outstanding
        rsp_rdy = 1'b0; req_vld = 1'b1;
        req_adr = 13'h20; cycle();
        req_adr = 13'h21; cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; req_vld = 1'b0; rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("midrst_infl_cnt", obs_infl_cnt, 0);
        chk("midrst_fifo_cnt", obs_fifo_cnt, 0);
        chk("midrst_err", obs_err, 0);

        // Spurious return with nothing in flight
        spur = 1'b1; spur_data = 32'hDEAD_BEEF;
        cycle();
        cycle();
        chk("spur_err_set", obs_err, 1);
        chk("spur_fifo_cnt", obs_fifo_cnt, 0);
        for (int i = 0; i < 3; i++) cycle();
        chk("spur_err_sticky", obs_err, 1);
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        chk("spur_err_cleared", obs_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
